split_join_ctl: RTL and testbench
=================================

Name: split_join_ctl

Overview:
- Per-warp split/join controller that drives the IPDOM divergence stack.
- On split: computes then/else thread masks, pushes restore state onto the stack, emits the new active mask.
- On join: pops the stack and emits either the else-path mask+PC or the restored pre-split mask.
- Sits between warp control decode and the warp scheduler's tmask/PC update path.

Parameters:
NUM_THREADS, 4, threads per warp (mask width)
PC_WIDTH, 32, program counter width
Stack entry width is fixed at NUM_THREADS+PC_WIDTH, packed {tmask, pc}.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
split_valid  in  1  split request
split_ready  out  1  split accepted when valid&ready
split_tmask  in  NUM_THREADS  current active mask
split_pred  in  NUM_THREADS  per-thread predicate
split_else_pc  in  PC_WIDTH  else-path start PC
join_valid  in  1  join request
join_ready  out  1  join accepted when valid&ready
ctl_valid  out  1  one-cycle result pulse
ctl_tmask  out  NUM_THREADS  new active mask
ctl_pc  out  PC_WIDTH  PC to jump to
ctl_pc_valid  out  1  ctl_pc must be applied
ctl_diverged  out  1  split was divergent
stk_push  out  1  stack push
stk_pop  out  1  stack pop
stk_pair  out  1  pushed entry is a two-half pair
stk_q1  out  NUM_THREADS+PC_WIDTH  restore half {tmask, pc}
stk_q2  out  NUM_THREADS+PC_WIDTH  else half {tmask, pc}
stk_d  in  NUM_THREADS+PC_WIDTH  stack top (combinational read)
stk_index  in  1  0 = top is else half, 1 = restore half
stk_empty  in  1  stack empty
stk_full  in  1  stack full
err_underflow  out  1  sticky: join on empty stack

Behaviour:
- FSM: IDLE, RESP. Requests are accepted only in IDLE. Each fire moves IDLE->RESP; RESP->IDLE unconditionally. Max throughput: 1 op per 2 cycles.
- split_ready = IDLE & ~stk_full & reset.
- join_ready = IDLE & ~split_valid & reset. Split has priority; push and pop never occur in the same cycle.
- stk_push/stk_pop are combinational from the fire cycle (T) and last one cycle only. stk_q1, stk_q2 and stk_pair are valid only when stk_push=1; otherwise they are 0.
- Split arithmetic: then = tmask & pred; else = tmask & ~pred. Divergent iff then != 0 && else != 0.
- Divergent split:
  - push with pair=1, q1 = {tmask, 0}, q2 = {else, split_else_pc}.
  - At T+1: ctl_tmask = then, ctl_diverged = 1, ctl_pc_valid = 0.
- Non-divergent split (includes tmask=0):
  - push with pair=0, q1 = {tmask, 0}, q2 = 0.
  - At T+1: ctl_tmask = tmask, ctl_diverged = 0, ctl_pc_valid = 0.
- Join with stk_empty=0: stk_pop at T; stk_d and stk_index are sampled at T.
  - stk_index=0: at T+1, ctl_tmask = d.tmask, ctl_pc = d.pc, ctl_pc_valid = 1.
  - stk_index=1: at T+1, ctl_tmask = d.tmask, ctl_pc_valid = 0.
- Join with stk_empty=1: the join is accepted but no pop is issued. err_underflow is set and holds until reset. At T+1: ctl_tmask = all ones, ctl_pc_valid = 0.
- ctl_* outputs are registered, valid only while ctl_valid=1, and 0 otherwise.
- ctl_pc = 0 whenever ctl_pc_valid = 0.
- Reset (sync, reset=0): state=IDLE; all outputs 0, including ready, ctl_*, stk_* and err_underflow. Reset during RESP drops the pending ctl pulse.

Optional Feature:
SPLIT_JOIN_PERF_EN
- Defined: adds outputs perf_splits[31:0], perf_divergent[31:0] and perf_max_depth[7:0].
  - perf_splits counts every accepted split; perf_divergent counts divergent splits.
  - Depth model: +1 per push; -1 per pop with stk_index=1; pop with stk_index=0 leaves depth unchanged.
  - perf_max_depth is the high-water mark of the depth model.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: no perf ports and no counter logic.

Test Plan:
- Divergent split, tmask=1111, pred=0011, else_pc=0x100 -> T: stk_push=1, stk_pair=1, q1={1111,0}, q2={1100,0x100}. T+1: ctl_tmask=0011, ctl_diverged=1.
- Join with stk_index=0, d={1100,0x100} -> stk_pop=1; T+1: ctl_tmask=1100, ctl_pc=0x100, ctl_pc_valid=1. Next join with stk_index=1, d={1111,0} -> ctl_tmask=1111, ctl_pc_valid=0.
- Non-divergent split, tmask=1010, pred=1111 -> stk_pair=0, q1={1010,0}; T+1: ctl_tmask=1010, ctl_diverged=0.
- split_valid=1 with stk_full=1 -> split_ready=0, no push, no ctl_valid. Deassert stk_full -> accepted next IDLE cycle.
- split_valid and join_valid together -> split fires; join_ready=0 that cycle; the join fires after the RESP cycle. Join with stk_empty=1 -> no pop, err_underflow=1, ctl_tmask=1111.
- reset=0 asserted in RESP -> ctl_valid=0 next cycle, all outputs 0, err_underflow cleared.

Source files
------------

// File: rtl/split_join_ctl.sv
// Per-warp split/join controller driving the IPDOM divergence stack.
// Optional perf counters are enabled by defining SPLIT_JOIN_PERF_EN.
module split_join_ctl #(
    parameter int NUM_THREADS = 4,
    parameter int PC_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          split_valid,
    output logic                          split_ready,
    input  logic [NUM_THREADS-1:0]        split_tmask,
    input  logic [NUM_THREADS-1:0]        split_pred,
    input  logic [PC_WIDTH-1:0]           split_else_pc,
    input  logic                          join_valid,
    output logic                          join_ready,
    output logic                          ctl_valid,
    output logic [NUM_THREADS-1:0]        ctl_tmask,
    output logic [PC_WIDTH-1:0]           ctl_pc,
    output logic                          ctl_pc_valid,
    output logic                          ctl_diverged,
    output logic                          stk_push,
    output logic                          stk_pop,
    output logic                          stk_pair,
    output logic [NUM_THREADS+PC_WIDTH-1:0] stk_q1,
    output logic [NUM_THREADS+PC_WIDTH-1:0] stk_q2,
    input  logic [NUM_THREADS+PC_WIDTH-1:0] stk_d,
    input  logic                          stk_index,
    input  logic                          stk_empty,
    input  logic                          stk_full,
    output logic                          err_underflow
`ifdef SPLIT_JOIN_PERF_EN
    ,
    output logic [31:0]                   perf_splits,
    output logic [31:0]                   perf_divergent,
    output logic [7:0]                    perf_max_depth
`endif
);

    localparam int EW = NUM_THREADS + PC_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   split_fire_s;
    logic                   join_fire_s;
    logic                   diverge_s;
    logic [NUM_THREADS-1:0] then_s;
    logic [NUM_THREADS-1:0] else_s;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: every accepted request costs exactly one response cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (split_fire_s || join_fire_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake, split arithmetic and stack command outputs
    always_comb begin
        then_s       = split_tmask & split_pred;
        else_s       = split_tmask & ~split_pred;
        diverge_s    = (then_s != {NUM_THREADS{1'b0}}) && (else_s != {NUM_THREADS{1'b0}});
        split_ready  = (state_r == ST_IDLE) & ~stk_full & reset;
        join_ready   = (state_r == ST_IDLE) & ~split_valid & reset;
        split_fire_s = split_valid & split_ready;
        join_fire_s  = join_valid & join_ready;
        stk_push     = split_fire_s;
        stk_pop      = join_fire_s & ~stk_empty;
        stk_pair     = 1'b0;
        stk_q1       = {EW{1'b0}};
        stk_q2       = {EW{1'b0}};
        if (split_fire_s) begin
            stk_pair = diverge_s;
            stk_q1   = {split_tmask, {PC_WIDTH{1'b0}}};
            if (diverge_s) begin
                stk_q2 = {else_s, split_else_pc};
            end else begin
                stk_q2 = {EW{1'b0}};
            end
        end else begin
            stk_pair = 1'b0;
        end
    end

    // Registered result pulse and sticky underflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctl_valid     <= 1'b0;
            ctl_tmask     <= {NUM_THREADS{1'b0}};
            ctl_pc        <= {PC_WIDTH{1'b0}};
            ctl_pc_valid  <= 1'b0;
            ctl_diverged  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            ctl_valid     <= split_fire_s | join_fire_s;
            ctl_tmask     <= {NUM_THREADS{1'b0}};
            ctl_pc        <= {PC_WIDTH{1'b0}};
            ctl_pc_valid  <= 1'b0;
            ctl_diverged  <= 1'b0;
            err_underflow <= err_underflow | (join_fire_s & stk_empty);
            if (split_fire_s) begin
                ctl_tmask    <= diverge_s ? then_s : split_tmask;
                ctl_diverged <= diverge_s;
            end else if (join_fire_s) begin
                if (stk_empty) begin
                    ctl_tmask <= {NUM_THREADS{1'b1}};
                end else if (!stk_index) begin
                    // Else half on top: jump to the else path
                    ctl_tmask    <= stk_d[EW-1:PC_WIDTH];
                    ctl_pc       <= stk_d[PC_WIDTH-1:0];
                    ctl_pc_valid <= 1'b1;
                end else begin
                    ctl_tmask <= stk_d[EW-1:PC_WIDTH];
                end
            end
        end
    end

`ifdef SPLIT_JOIN_PERF_EN
    logic [7:0] depth_r;
    logic [7:0] depth_inc_s;

    assign depth_inc_s = depth_r + 8'd1;

    // Split counters and stack depth high-water mark
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_splits    <= 32'd0;
            perf_divergent <= 32'd0;
            perf_max_depth <= 8'd0;
            depth_r        <= 8'd0;
        end else begin
            if (split_fire_s) begin
                perf_splits <= perf_splits + 32'd1;
            end
            if (split_fire_s && diverge_s) begin
                perf_divergent <= perf_divergent + 32'd1;
            end
            if (stk_push) begin
                depth_r <= depth_inc_s;
                if (depth_inc_s > perf_max_depth) begin
                    perf_max_depth <= depth_inc_s;
                end
            end else if (stk_pop && stk_index && (depth_r != 8'd0)) begin
                depth_r <= depth_r - 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_split_join_ctl.sv
// Directed self-checking bench for split_join_ctl (default build, no perf ports).
module tb_split_join_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        split_valid;
    logic        split_ready;
    logic [3:0]  split_tmask;
    logic [3:0]  split_pred;
    logic [31:0] split_else_pc;
    logic        join_valid;
    logic        join_ready;
    logic        ctl_valid;
    logic [3:0]  ctl_tmask;
    logic [31:0] ctl_pc;
    logic        ctl_pc_valid;
    logic        ctl_diverged;
    logic        stk_push;
    logic        stk_pop;
    logic        stk_pair;
    logic [35:0] stk_q1;
    logic [35:0] stk_q2;
    logic [35:0] stk_d;
    logic        stk_index;
    logic        stk_empty;
    logic        stk_full;
    logic        err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    split_join_ctl #(.NUM_THREADS(4), .PC_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .split_valid(split_valid), .split_ready(split_ready),
        .split_tmask(split_tmask), .split_pred(split_pred), .split_else_pc(split_else_pc),
        .join_valid(join_valid), .join_ready(join_ready),
        .ctl_valid(ctl_valid), .ctl_tmask(ctl_tmask), .ctl_pc(ctl_pc),
        .ctl_pc_valid(ctl_pc_valid), .ctl_diverged(ctl_diverged),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_pair(stk_pair),
        .stk_q1(stk_q1), .stk_q2(stk_q2), .stk_d(stk_d), .stk_index(stk_index),
        .stk_empty(stk_empty), .stk_full(stk_full), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; split_valid = 1'b0; split_tmask = 4'h0; split_pred = 4'h0;
        split_else_pc = 32'h0; join_valid = 1'b0; stk_d = 36'h0; stk_index = 1'b0;
        stk_empty = 1'b0; stk_full = 1'b0;
        step(); step();
        check("rst_split_ready", split_ready, 1'b0);
        check("rst_join_ready", join_ready, 1'b0);
        check("rst_ctl_valid", ctl_valid, 1'b0);
        check("rst_err", err_underflow, 1'b0);
        check("rst_push", stk_push, 1'b0);
        reset = 1'b1;
        step();
        check("idle_split_ready", split_ready, 1'b1);
        check("idle_join_ready", join_ready, 1'b1);

        // Divergent split
        split_valid = 1'b1; split_tmask = 4'hF; split_pred = 4'h3; split_else_pc = 32'h100;
        #1;
        check("div_push", stk_push, 1'b1);
        check("div_pair", stk_pair, 1'b1);
        check("div_q1", stk_q1, 36'hF_0000_0000);
        check("div_q2", stk_q2, 36'hC_0000_0100);
        check("div_join_ready", join_ready, 1'b0);
        step(); split_valid = 1'b0; #1;
        check("div_ctl_valid", ctl_valid, 1'b1);
        check("div_ctl_tmask", ctl_tmask, 4'h3);
        check("div_ctl_diverged", ctl_diverged, 1'b1);
        check("div_ctl_pc_valid", ctl_pc_valid, 1'b0);
        check("div_ctl_pc", ctl_pc, 32'h0);
        check("resp_split_ready", split_ready, 1'b0);
        check("resp_push", stk_push, 1'b0);
        check("resp_q1", stk_q1, 36'h0);
        step();
        check("div_pulse_end", ctl_valid, 1'b0);

        // Join onto else half
        join_valid = 1'b1; stk_d = 36'hC_0000_0100; stk_index = 1'b0; #1;
        check("j0_pop", stk_pop, 1'b1);
        step(); join_valid = 1'b0; #1;
        check("j0_ctl_valid", ctl_valid, 1'b1);
        check("j0_ctl_tmask", ctl_tmask, 4'hC);
        check("j0_ctl_pc", ctl_pc, 32'h100);
        check("j0_ctl_pc_valid", ctl_pc_valid, 1'b1);
        step();

        // Join onto restore half
        join_valid = 1'b1; stk_d = 36'hF_0000_0000; stk_index = 1'b1; #1;
        check("j1_pop", stk_pop, 1'b1);
        step(); join_valid = 1'b0; #1;
        check("j1_ctl_tmask", ctl_tmask, 4'hF);
        check("j1_ctl_pc_valid", ctl_pc_valid, 1'b0);
        check("j1_ctl_pc", ctl_pc, 32'h0);
        step();

        // Non-divergent split
        split_valid = 1'b1; split_tmask = 4'hA; split_pred = 4'hF; #1;
        check("nd_pair", stk_pair, 1'b0);
        check("nd_q1", stk_q1, 36'hA_0000_0000);
        check("nd_q2", stk_q2, 36'h0);
        step(); split_valid = 1'b0; #1;
        check("nd_ctl_tmask", ctl_tmask, 4'hA);
        check("nd_ctl_diverged", ctl_diverged, 1'b0);
        step();

        // Empty-mask split is non-divergent
        split_valid = 1'b1; split_tmask = 4'h0; split_pred = 4'hF; #1;
        check("z_pair", stk_pair, 1'b0);
        step(); split_valid = 1'b0; #1;
        check("z_ctl_valid", ctl_valid, 1'b1);
        check("z_ctl_tmask", ctl_tmask, 4'h0);
        check("z_ctl_diverged", ctl_diverged, 1'b0);
        step();

        // Stack full back-pressure
        split_valid = 1'b1; split_tmask = 4'hF; split_pred = 4'h3; stk_full = 1'b1; #1;
        check("full_ready", split_ready, 1'b0);
        check("full_push", stk_push, 1'b0);
        step();
        check("full_ctl_valid", ctl_valid, 1'b0);
        stk_full = 1'b0; #1;
        check("unfull_ready", split_ready, 1'b1);
        check("unfull_push", stk_push, 1'b1);
        step(); split_valid = 1'b0; #1;
        check("unfull_ctl_tmask", ctl_tmask, 4'h3);
        step();

        // Split wins over join; join then hits an empty stack
        split_valid = 1'b1; join_valid = 1'b1; split_tmask = 4'h5; split_pred = 4'h5;
        stk_empty = 1'b1; #1;
        check("prio_join_ready", join_ready, 1'b0);
        check("prio_push", stk_push, 1'b1);
        check("prio_pop", stk_pop, 1'b0);
        step(); split_valid = 1'b0; #1;
        check("prio_resp_join_ready", join_ready, 1'b0);
        check("prio_ctl_tmask", ctl_tmask, 4'h5);
        step();
        check("emp_join_ready", join_ready, 1'b1);
        check("emp_pop", stk_pop, 1'b0);
        check("emp_err_before", err_underflow, 1'b0);
        step(); join_valid = 1'b0; #1;
        check("emp_ctl_valid", ctl_valid, 1'b1);
        check("emp_ctl_tmask", ctl_tmask, 4'hF);
        check("emp_ctl_pc_valid", ctl_pc_valid, 1'b0);
        check("emp_err", err_underflow, 1'b1);
        step();
        check("emp_err_sticky", err_underflow, 1'b1);
        check("emp_pulse_end", ctl_valid, 1'b0);
        stk_empty = 1'b0;

        // Reset asserted during RESP
        split_valid = 1'b1; split_tmask = 4'hF; split_pred = 4'h3; split_else_pc = 32'h200;
        step(); split_valid = 1'b0; #1;
        check("rr_ctl_valid", ctl_valid, 1'b1);
        reset = 1'b0; #1;
        check("rr_split_ready", split_ready, 1'b0);
        check("rr_join_ready", join_ready, 1'b0);
        step();
        check("rr_ctl_valid_after", ctl_valid, 1'b0);
        check("rr_ctl_tmask", ctl_tmask, 4'h0);
        check("rr_err", err_underflow, 1'b0);
        check("rr_push", stk_push, 1'b0);
        reset = 1'b1;
        step();
        check("rr_idle_ready", split_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
